// File: rtl/reaction_ctrl_if.sv
// Groups the reaction controller's player/sequencer inputs and result outputs.
// Latency: none, this is wiring only.
// Backpressure: none, all signals are single-cycle strobes or held levels.
interface reaction_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             tick;
    logic             lights_out;
    logic             button;
    logic             clear_best;
    logic             seq_start;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] react_time;
    logic [WIDTH-1:0] best_time;
    logic             jump_start;
    logic             timeout;

    // Driver side: the surrounding game logic and the player.
    modport master (
        output start, tick, lights_out, button, clear_best,
        input  seq_start, busy, result_valid, react_time, best_time, jump_start, timeout
    );

    // Controller side.
    modport slave (
        input  start, tick, lights_out, button, clear_best,
        output seq_start, busy, result_valid, react_time, best_time, jump_start, timeout
    );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: arms the light sequencer, times the press in ms ticks, tracks the best time.
// Latency: result_valid is high the cycle after the deciding press or tick edge.
// Backpressure: none; start is only honoured in IDLE, every other input is a strobe sampled each cycle.
module reaction_ctrl #(
    parameter int WIDTH  = 16,
    parameter int MAX_MS = 2000
) (
    input  logic           clk,
    input  logic           rst,
    reaction_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_LIGHTS,
        MEASURE,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX_MS);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] react_q, react_d;
    logic [WIDTH-1:0] best_q, best_d;
    logic             jump_q, jump_d;
    logic             to_q, to_d;
    logic             button_q, button_d;

    logic             press;
    logic [WIDTH-1:0] cnt_inc;
    logic             cnt_at_limit;

    // Rising edge of the already-synchronised button; a button held across
    // round boundaries therefore never counts as a press.
    assign press        = bus.button & ~button_q;
    assign cnt_inc      = cnt_q + ONE;
    // The tick that would land the counter on MAX_MS is the timeout, so the
    // counter itself never reaches MAX_MS and can never wrap.
    assign cnt_at_limit = (cnt_inc == MAX_VAL);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a press always takes priority over lights_out and tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (bus.start) state_d = ARM;
            ARM:         state_d = WAIT_LIGHTS;
            WAIT_LIGHTS: begin
                if (press)               state_d = DONE;
                else if (bus.lights_out) state_d = MEASURE;
            end
            MEASURE: begin
                if (press)                        state_d = DONE;
                else if (bus.tick && cnt_at_limit) state_d = DONE;
            end
            DONE:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; DONE is only entered with a fresh result.
    always_comb begin
        bus.seq_start    = (state_q == ARM);
        bus.busy         = (state_q != IDLE);
        bus.result_valid = (state_q == DONE);
    end

    assign bus.react_time = react_q;
    assign bus.best_time  = best_q;
    assign bus.jump_start = jump_q;
    assign bus.timeout    = to_q;

    // Datapath next values: counter, result registers and best-time tracker.
    always_comb begin
        cnt_d    = cnt_q;
        react_d  = react_q;
        best_d   = best_q;
        jump_d   = jump_q;
        to_d     = to_q;
        button_d = bus.button;
        case (state_q)
            WAIT_LIGHTS: begin
                if (press) begin
                    // Press before or together with lights_out is a jump start.
                    jump_d  = 1'b1;
                    to_d    = 1'b0;
                    react_d = '0;
                end else if (bus.lights_out) begin
                    cnt_d = '0;
                end
            end
            MEASURE: begin
                if (press) begin
                    // Capture the pre-increment value even if a tick coincides.
                    react_d = cnt_q;
                    jump_d  = 1'b0;
                    to_d    = 1'b0;
                    if (cnt_q < best_q) best_d = cnt_q;
                end else if (bus.tick) begin
                    if (cnt_at_limit) begin
                        react_d = MAX_VAL;
                        jump_d  = 1'b0;
                        to_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: ;
        endcase
        // Clearing overrides any same-cycle best-time update.
        if (bus.clear_best) best_d = ALL_ONES;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            react_q  <= '0;
            best_q   <= ALL_ONES;
            jump_q   <= 1'b0;
            to_q     <= 1'b0;
            button_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            react_q  <= react_d;
            best_q   <= best_d;
            jump_q   <= jump_d;
            to_q     <= to_d;
            button_q <= button_d;
        end
    end
endmodule

// File: doc/reaction_ctrl.md
REACTION_CTRL -- requirements
Module: reaction_ctrl

Interface
REQ-001 The parameter WIDTH SHALL default to 16 and set the width of the millisecond counter and of all time outputs.
REQ-002 The parameter MAX_MS SHALL default to 2000 and set the reaction timeout in ticks.
REQ-003 clk  in  1  Single system clock; all state SHALL change on its rising edge.
REQ-004 rst  in  1  Reset, asynchronous assert, active-low (0 = reset).
REQ-005 start  in  1  Request to begin a round; level-sampled.
REQ-006 tick  in  1  One-cycle 1 ms strobe from the tick generator.
REQ-007 lights_out  in  1  One-cycle pulse from the light sequencer when the last light goes out.
REQ-008 button  in  1  Player button, already synchronised to clk.
REQ-009 clear_best  in  1  Resets best_time to all-ones.
REQ-010 seq_start  out  1  One-cycle pulse that triggers the light sequencer.
REQ-011 busy  out  1  High in every state except IDLE.
REQ-012 result_valid  out  1  One-cycle pulse when react_time, jump_start and timeout are updated.
REQ-013 react_time  out  WIDTH  Last measured reaction time in ms.
REQ-014 best_time  out  WIDTH  Smallest valid reaction time since reset or clear_best.
REQ-015 jump_start  out  1  Last round ended with a press before lights_out.
REQ-016 timeout  out  1  Last round ended with no press within MAX_MS ticks.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, ARM, WAIT_LIGHTS, MEASURE and DONE.
REQ-018 Button rising-edge detection SHALL use a registered copy of button; press = button & ~button_q.
REQ-019 IDLE: start=1 SHALL move the FSM to ARM on the next edge; start is ignored in all other states.
REQ-020 ARM: seq_start=1 for exactly this one cycle, then unconditionally WAIT_LIGHTS.
REQ-021 WAIT_LIGHTS: press SHALL set jump_start=1, timeout=0, react_time=0, pulse result_valid, go to DONE; best_time is unchanged.
REQ-022 WAIT_LIGHTS: press and lights_out in the same cycle SHALL be treated as a jump start.
REQ-023 WAIT_LIGHTS: lights_out without press SHALL clear the counter to 0 and go to MEASURE.
REQ-024 MEASURE: each tick without press SHALL increment the counter by 1.
REQ-025 MEASURE: press SHALL set react_time to the current counter value and clear jump_start and timeout; when tick coincides, the value before increment is captured.
REQ-026 MEASURE: press SHALL also pulse result_valid and go to DONE.
REQ-027 On a valid press, best_time SHALL load react_time when react_time < best_time (strict).
REQ-028 MEASURE: a tick that would make the counter equal MAX_MS without press SHALL set timeout=1, react_time=MAX_MS and pulse result_valid.
REQ-029 On that timeout, best_time SHALL be unchanged and the FSM SHALL go to DONE.
REQ-030 DONE: SHALL return to IDLE after one cycle; button level is ignored until the next round.
REQ-031 The counter SHALL never wrap; MAX_MS SHALL be less than 2^WIDTH.
REQ-032 clear_best SHALL take effect in any state; when clear_best coincides with a best_time update, clear_best wins.
REQ-033 react_time, jump_start and timeout SHALL hold their values until the next result_valid.

Reset
REQ-034 While rst=0: state=IDLE, counter=0, button_q=0, seq_start=0, busy=0, result_valid=0, react_time=0, best_time=all-ones, jump_start=0, timeout=0.
REQ-035 Reset asserted mid-round SHALL abandon the round with no result_valid pulse.
REQ-036 After reset release, operation SHALL resume from IDLE on the first clock edge.

Verification
REQ-037 Normal round: start, lights_out, 250 ticks, then press -> react_time=250, result_valid for 1 cycle, best_time=250, jump_start=0, timeout=0.
REQ-038 Best tracking: rounds of 300, then 180, then 180 -> best_time=300, then 180, then 180 (no update on the equal round).
REQ-039 Jump start: press 5 cycles after seq_start, before lights_out -> jump_start=1, react_time=0, best_time unchanged.
REQ-040 Jump-start tie: press in the same cycle as lights_out -> jump_start=1.
REQ-041 Timeout: lights_out, then 2000 ticks with no press -> timeout=1, react_time=2000, one result_valid pulse, FSM in IDLE 2 cycles later.
REQ-042 Tie: press in the same cycle as the 100th tick -> react_time=99.
REQ-043 Reset/clear: rst=0 during MEASURE -> no result_valid, busy=0; clear_best pulse -> best_time=16'hFFFF.
REQ-044 Busy start: start held high during MEASURE -> no second seq_start pulse.
